cntr_bs_dp_gen: RTL and testbench

Parametrised datapath for the bank scheduler, successor to the fixed 4-read/3-write datapath. It holds any number of read and write request FIFOs and accepts one-hot push/pop from the bank scheduler control. It returns the popped request through a registered exit stage with a valid strobe, and it exports per-FIFO occupancy, tail row address, head burst, and sticky protocol-error flags. It sits between the transaction controller and the bank scheduler arbiter, replacing the hand-edited exit mux and one-hot decoder with width-generic logic.

---
 rtl/cntr_bs_dp_gen.sv | 194 +++++++++++++++++++
 tb/tb_cntr_bs_dp_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_bs_dp_gen.sv
// Bank-scheduler datapath: N read/write request FIFOs, one-hot push/pop, registered exit stage.
// Latency: a push shows in status one cycle later. A popped request reaches the exit register one cycle after the pop.
// Backpressure: a push to a full FIFO is refused (grant=0) unless that same FIFO is also popped this cycle.
module cntr_bs_dp_gen #(
    parameter int   RD_FIFO_NUM  = 4,
    parameter int   WR_FIFO_NUM  = 3,
    parameter int   RD_FIFO_SIZE = 4,
    parameter int   WR_FIFO_SIZE = 3,
    parameter int   DQ           = 16,
    parameter int   IDX          = 6,
    parameter int   RA           = 16,
    parameter int   CA           = 10,
    parameter logic READ         = 1'b1,
    parameter logic WRITE        = 1'b0,
    localparam int  N            = RD_FIFO_NUM + WR_FIFO_NUM,
    localparam int  MAX_SIZE     = (RD_FIFO_SIZE > WR_FIFO_SIZE) ? RD_FIFO_SIZE : WR_FIFO_SIZE,
    localparam int  CNT_W        = $clog2(MAX_SIZE + 1),
    localparam int  FB_W         = RA + CA - 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            push,
    input  logic [N-1:0]            pop,
    input  logic [DQ-1:0]           dq_i,
    input  logic [IDX-1:0]          idx_i,
    input  logic [RA-1:0]           ra_i,
    input  logic [CA-1:0]           ca_i,
    output logic                    grant,
    output logic [N-1:0]            full,
    output logic [N-1:0]            empty,
    output logic [N-1:0]            mid,
    output logic [N-1:0][CNT_W-1:0] count,
    output logic [N-1:0][RA-1:0]    last_ra,
    output logic [N-1:0][FB_W-1:0]  first_burst,
    output logic                    out_valid,
    output logic [DQ-1:0]           dq_o,
    output logic [IDX-1:0]          idx_o,
    output logic [RA-1:0]           ra_o,
    output logic [CA-1:0]           ca_o,
    output logic                    type_o,
    output logic                    err_ovf,
    output logic                    err_udf,
    output logic                    err_hot
);

    localparam int PTR_W = $clog2(MAX_SIZE);
    localparam int DEPTH = 1 << PTR_W;
    localparam int SEL_W = $clog2(N);

    typedef struct packed {
        logic [DQ-1:0]  dq;
        logic [IDX-1:0] idx;
        logic [RA-1:0]  ra;
        logic [CA-1:0]  ca;
    } req_t;

    logic         push_hot, pop_hot, push_multi, pop_multi;
    logic [N-1:0] push_acc, pop_acc;
    logic         ovf_set, udf_set, hot_set;
    req_t         head [N];

    // A single bit set means exactly one target; x & (x-1) clears the lowest set bit.
    assign push_hot   = (push != '0) && ((push & (push - N'(1))) == '0);
    assign pop_hot    = (pop  != '0) && ((pop  & (pop  - N'(1))) == '0);
    assign push_multi = (push != '0) && !push_hot;
    assign pop_multi  = (pop  != '0) && !pop_hot;

    assign pop_acc  = pop_hot  ? (pop & ~empty) : '0;
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign push_acc = push_hot ? (push & (~full | pop_acc)) : '0;
    assign grant    = |push_acc;

    assign ovf_set = push_hot && ((push & full & ~pop_acc) != '0);
    assign udf_set = pop_hot && ((pop & empty) != '0);
    assign hot_set = push_multi || pop_multi;

    for (genvar k = 0; k < N; k++) begin : g_fifo
        localparam int SZ = (k < RD_FIFO_NUM) ? RD_FIFO_SIZE : WR_FIFO_SIZE;

        req_t             mem_q [DEPTH];
        logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt, wr_ptr_nxt;
        logic [CNT_W-1:0] cnt_q, cnt_nxt;
        logic [RA-1:0]    last_ra_q;
        logic [FB_W-1:0]  fb_q, fb_nxt;
        logic             fb_from_push;
        req_t             wr_ent;

        always_comb begin
            wr_ent     = '0;
            wr_ent.idx = idx_i;
            wr_ent.ra  = ra_i;
            wr_ent.ca  = ca_i;
            if (k >= RD_FIFO_NUM) begin
                wr_ent.dq = dq_i;
            end
        end

        assign rd_ptr_nxt = !pop_acc[k] ? rd_ptr_q :
                            (rd_ptr_q == PTR_W'(SZ - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        assign wr_ptr_nxt = !push_acc[k] ? wr_ptr_q :
                            (wr_ptr_q == PTR_W'(SZ - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

        always_comb begin
            cnt_nxt = cnt_q;
            if (push_acc[k] && !pop_acc[k]) begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end else if (pop_acc[k] && !push_acc[k]) begin
                cnt_nxt = cnt_q - CNT_W'(1);
            end
        end

        // The next head is the entry being written when it lands exactly at the next read slot.
        assign fb_from_push = push_acc[k] && (wr_ptr_q == rd_ptr_nxt);
        assign fb_nxt = fb_from_push ? {wr_ent.ra, wr_ent.ca[CA-1:4]}
                                     : {mem_q[rd_ptr_nxt].ra, mem_q[rd_ptr_nxt].ca[CA-1:4]};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                cnt_q     <= '0;
                last_ra_q <= '0;
                fb_q      <= '0;
            end else begin
                if (push_acc[k]) begin
                    mem_q[wr_ptr_q] <= wr_ent;
                    last_ra_q       <= ra_i;
                end
                rd_ptr_q <= rd_ptr_nxt;
                wr_ptr_q <= wr_ptr_nxt;
                cnt_q    <= cnt_nxt;
                // An empty FIFO keeps showing its last head.
                if (cnt_nxt != '0) begin
                    fb_q <= fb_nxt;
                end
            end
        end

        assign head[k]        = mem_q[rd_ptr_q];
        assign count[k]       = cnt_q;
        assign full[k]        = (cnt_q == CNT_W'(SZ));
        assign empty[k]       = (cnt_q == '0);
        assign mid[k]         = (cnt_q >= CNT_W'(SZ / 2));
        assign last_ra[k]     = last_ra_q;
        assign first_burst[k] = fb_q;
    end

    logic [SEL_W-1:0] pop_sel;
    req_t             sel_ent;
    logic             sel_wr;

    // One-hot to index by OR-ing indices; only meaningful when pop is one-hot.
    always_comb begin
        pop_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (pop[k]) begin
                pop_sel = pop_sel | SEL_W'(k);
            end
        end
    end

    assign sel_ent = head[pop_sel];
    assign sel_wr  = (pop_sel >= SEL_W'(RD_FIFO_NUM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dq_o      <= '0;
            idx_o     <= '0;
            ra_o      <= '0;
            ca_o      <= '0;
            type_o    <= 1'b0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
            err_hot   <= 1'b0;
        end else begin
            out_valid <= |pop_acc;
            if (|pop_acc) begin
                dq_o   <= sel_wr ? sel_ent.dq : '0;
                idx_o  <= sel_ent.idx;
                ra_o   <= sel_ent.ra;
                ca_o   <= sel_ent.ca;
                type_o <= sel_wr ? WRITE : READ;
            end
            err_ovf <= err_ovf | ovf_set;
            err_udf <= err_udf | udf_set;
            err_hot <= err_hot | hot_set;
        end
    end

endmodule

// File: tb/tb_cntr_bs_dp_gen.sv
// Bench for cntr_bs_dp_gen: default 4R/3W instance driven from a vector table with a queue model
// for exits, plus a hand sequence on an 8R/5W instance and mid-stream resets.
module tb_cntr_bs_dp_gen;
    localparam int N  = 7;
    localparam int N2 = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    push, pop;
    logic [N2-1:0]   push2, pop2;
    logic [15:0]     dq_i, ra_i;
    logic [5:0]      idx_i;
    logic [9:0]      ca_i;

    logic                 grant, out_valid, type_o, err_ovf, err_udf, err_hot;
    logic [N-1:0]         full, empty, mid;
    logic [N-1:0][2:0]    count;
    logic [N-1:0][15:0]   last_ra;
    logic [N-1:0][21:0]   first_burst;
    logic [15:0]          dq_o, ra_o;
    logic [5:0]           idx_o;
    logic [9:0]           ca_o;

    logic                 grant2, out_valid2, type_o2, err_ovf2, err_udf2, err_hot2;
    logic [N2-1:0]        full2, empty2, mid2;
    logic [N2-1:0][2:0]   count2;
    logic [N2-1:0][15:0]  last_ra2;
    logic [N2-1:0][21:0]  first_burst2;
    logic [15:0]          dq_o2, ra_o2;
    logic [5:0]           idx_o2;
    logic [9:0]           ca_o2;

    cntr_bs_dp_gen dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .dq_i(dq_i), .idx_i(idx_i), .ra_i(ra_i), .ca_i(ca_i),
        .grant(grant), .full(full), .empty(empty), .mid(mid), .count(count),
        .last_ra(last_ra), .first_burst(first_burst), .out_valid(out_valid),
        .dq_o(dq_o), .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o), .type_o(type_o),
        .err_ovf(err_ovf), .err_udf(err_udf), .err_hot(err_hot)
    );

    cntr_bs_dp_gen #(.RD_FIFO_NUM(8), .WR_FIFO_NUM(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .push(push2), .pop(pop2),
        .dq_i(dq_i), .idx_i(idx_i), .ra_i(ra_i), .ca_i(ca_i),
        .grant(grant2), .full(full2), .empty(empty2), .mid(mid2), .count(count2),
        .last_ra(last_ra2), .first_burst(first_burst2), .out_valid(out_valid2),
        .dq_o(dq_o2), .idx_o(idx_o2), .ra_o(ra_o2), .ca_o(ca_o2), .type_o(type_o2),
        .err_ovf(err_ovf2), .err_udf(err_udf2), .err_hot(err_hot2)
    );

    typedef struct {
        logic [15:0] dq;
        logic [5:0]  idx;
        logic [15:0] ra;
        logic [9:0]  ca;
        logic        typ;
    } ent_t;

    typedef struct {
        logic [N-1:0] ps, pp;
        logic [15:0]  ra;
        logic [9:0]   ca;
        int           f;
        logic         g;
        logic [2:0]   cnt;
        logic         fu, em, mi;
        logic [2:0]   err;
        logic [15:0]  lra;
        logic [21:0]  fb;
    } vec_t;

    ent_t mq [N][$];
    ent_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int sz(input int k);
        return (k < 4) ? 4 : 3;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] ps, pp, input logic [15:0] ra, input logic [9:0] ca,
                                input int f, input logic g, input logic [2:0] cnt, input logic fu, em, mi,
                                input logic [2:0] err, input logic [15:0] lra, fb_ra, input logic [5:0] fb_ca);
        vec_t v;
        v.ps = ps; v.pp = pp; v.ra = ra; v.ca = ca; v.f = f; v.g = g; v.cnt = cnt;
        v.fu = fu; v.em = em; v.mi = mi; v.err = err; v.lra = lra; v.fb = {fb_ra, fb_ca};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle on the default instance: drive, sample grant, update model, check exit after the edge.
    task automatic step(input logic [N-1:0] ps, pp, input logic [15:0] dq, ra,
                        input logic [9:0] ca, input logic [5:0] ix, output logic g);
        int   pf, qf;
        bit   pop_ok, push_ok;
        ent_t e;
        @(negedge clk);
        push = ps; pop = pp; dq_i = dq; ra_i = ra; ca_i = ca; idx_i = ix;
        push2 = '0; pop2 = '0;
        #1 g = grant;
        pf = -1; qf = -1;
        for (int k = 0; k < N; k++) begin
            if (ps[k]) pf = k;
            if (pp[k]) qf = k;
        end
        pop_ok = 1'b0;
        push_ok = 1'b0;
        if ($countones(pp) == 1) begin
            if (mq[qf].size() > 0) pop_ok = 1'b1;
        end
        if ($countones(ps) == 1) begin
            if (mq[pf].size() < sz(pf) || (pop_ok && qf == pf)) push_ok = 1'b1;
        end
        if (pop_ok) sb_q.push_back(mq[qf].pop_front());
        if (push_ok) begin
            e.dq = (pf >= 4) ? dq : 16'h0;
            e.idx = ix; e.ra = ra; e.ca = ca;
            e.typ = (pf >= 4) ? 1'b0 : 1'b1;
            mq[pf].push_back(e);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(pop_ok));
        if (pop_ok && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (out_valid) begin
                chk("exit_ra", 64'(ra_o), 64'(e.ra));
                chk("exit_dq", 64'(dq_o), 64'(e.dq));
                chk("exit_idx", 64'(idx_o), 64'(e.idx));
                chk("exit_ca", 64'(ca_o), 64'(e.ca));
                chk("exit_type", 64'(type_o), 64'(e.typ));
            end
        end
    endtask

    task automatic step2(input logic [N2-1:0] ps, pp, input logic [15:0] dq, ra, input logic ev,
                         input logic [15:0] era, edq, input logic etyp);
        @(negedge clk);
        push = '0; pop = '0; push2 = ps; pop2 = pp;
        dq_i = dq; ra_i = ra; ca_i = 10'h150; idx_i = 6'h2A;
        @(posedge clk);
        #1;
        chk("g2_out_valid", 64'(out_valid2), 64'(ev));
        if (ev) begin
            chk("g2_exit_ra", 64'(ra_o2), 64'(era));
            chk("g2_exit_dq", 64'(dq_o2), 64'(edq));
            chk("g2_exit_type", 64'(type_o2), 64'(etyp));
        end
    endtask

    task automatic do_reset(input bit with_push);
        @(negedge clk);
        rst_n = 1'b0;
        push  = with_push ? 7'b0000010 : '0;
        pop   = with_push ? 7'b0000100 : '0;
        push2 = with_push ? 13'h0001 : '0;
        pop2  = '0;
        @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(7'h7F));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_errs", 64'({err_ovf, err_udf, err_hot}), 64'(0));
        chk("rst_exit", 64'({dq_o, ra_o, idx_o, ca_o, type_o}), 64'(0));
        chk("rst_last_ra_any", 64'(|last_ra), 64'(0));
        chk("rst_first_burst_any", 64'(|first_burst), 64'(0));
        chk("rst2_count", 64'(count2), 64'(0));
        chk("rst2_empty", 64'(empty2), 64'(13'h1FFF));
        chk("rst2_errs", 64'({err_ovf2, err_udf2, err_hot2, out_valid2}), 64'(0));
        for (int k = 0; k < N; k++) mq[k].delete();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push = '0; pop = '0; push2 = '0; pop2 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [21];
        logic        g;
        int          f;
        logic [6:0]  F0, F1, F2, F5, F6;
        logic [9:0]  C;
        F0 = 7'h01; F1 = 7'h02; F2 = 7'h04; F5 = 7'h20; F6 = 7'h40; C = 10'h3F0;

        //            push   pop    ra     ca      f  g  cnt  fu em mi err lra     fb_ra  fb_ca
        vecs[0]  = mk(F0,    '0,    16'h10, C,      0, 1, 1,  0, 0, 0, 0, 16'h10, 16'h10, 6'h3F);
        vecs[1]  = mk(F0,    '0,    16'h11, C,      0, 1, 2,  0, 0, 1, 0, 16'h11, 16'h10, 6'h3F);
        vecs[2]  = mk(F0,    '0,    16'h12, C,      0, 1, 3,  0, 0, 1, 0, 16'h12, 16'h10, 6'h3F);
        vecs[3]  = mk(F0,    '0,    16'h13, C,      0, 1, 4,  1, 0, 1, 0, 16'h13, 16'h10, 6'h3F);
        vecs[4]  = mk(F0,    '0,    16'h14, C,      0, 0, 4,  1, 0, 1, 4, 16'h13, 16'h10, 6'h3F);
        vecs[5]  = mk('0,    F0,    16'h0,  C,      0, 0, 3,  0, 0, 1, 4, 16'h13, 16'h11, 6'h3F);
        vecs[6]  = mk('0,    F0,    16'h0,  C,      0, 0, 2,  0, 0, 1, 4, 16'h13, 16'h12, 6'h3F);
        vecs[7]  = mk('0,    F0,    16'h0,  C,      0, 0, 1,  0, 0, 0, 4, 16'h13, 16'h13, 6'h3F);
        vecs[8]  = mk('0,    F0,    16'h0,  C,      0, 0, 0,  0, 1, 0, 4, 16'h13, 16'h13, 6'h3F);
        vecs[9]  = mk(F5,    '0,    16'h50, C,      5, 1, 1,  0, 0, 1, 4, 16'h50, 16'h50, 6'h3F);
        vecs[10] = mk(F5,    '0,    16'h51, C,      5, 1, 2,  0, 0, 1, 4, 16'h51, 16'h50, 6'h3F);
        vecs[11] = mk(F5,    '0,    16'h52, C,      5, 1, 3,  1, 0, 1, 4, 16'h52, 16'h50, 6'h3F);
        vecs[12] = mk(F5,    F5,    16'h53, C,      5, 1, 3,  1, 0, 1, 4, 16'h53, 16'h51, 6'h3F);
        vecs[13] = mk('0,    F5,    16'h0,  C,      5, 0, 2,  0, 0, 1, 4, 16'h53, 16'h52, 6'h3F);
        vecs[14] = mk('0,    F5,    16'h0,  C,      5, 0, 1,  0, 0, 1, 4, 16'h53, 16'h53, 6'h3F);
        vecs[15] = mk('0,    F5,    16'h0,  C,      5, 0, 0,  0, 1, 0, 4, 16'h53, 16'h53, 6'h3F);
        vecs[16] = mk(F2,    F2,    16'h20, 10'h2A5, 2, 1, 1, 0, 0, 0, 6, 16'h20, 16'h20, 6'h2A);
        vecs[17] = mk(F0,    '0,    16'h30, C,      0, 1, 1,  0, 0, 0, 6, 16'h30, 16'h30, 6'h3F);
        vecs[18] = mk(F6,    7'h03, 16'h60, C,      6, 1, 1,  0, 0, 1, 7, 16'h60, 16'h60, 6'h3F);
        vecs[19] = mk(7'h05, '0,    16'h70, C,      0, 0, 1,  0, 0, 0, 7, 16'h30, 16'h30, 6'h3F);
        vecs[20] = mk(F1,    F0,    16'h40, C,      1, 1, 1,  0, 0, 0, 7, 16'h40, 16'h40, 6'h3F);

        rst_n = 1'b0;
        push = '0; pop = '0; push2 = '0; pop2 = '0;
        dq_i = '0; ra_i = '0; ca_i = '0; idx_i = '0;
        do_reset(1'b0);

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].ps, vecs[i].pp, 16'hD000 | 16'(i), vecs[i].ra, vecs[i].ca, 6'(i), g);
            f = vecs[i].f;
            chk($sformatf("grant[v%0d]", i), 64'(g), 64'(vecs[i].g));
            chk($sformatf("count[v%0d]", i), 64'(count[f]), 64'(vecs[i].cnt));
            chk($sformatf("full[v%0d]", i), 64'(full[f]), 64'(vecs[i].fu));
            chk($sformatf("empty[v%0d]", i), 64'(empty[f]), 64'(vecs[i].em));
            chk($sformatf("mid[v%0d]", i), 64'(mid[f]), 64'(vecs[i].mi));
            chk($sformatf("errs[v%0d]", i), 64'({err_ovf, err_udf, err_hot}), 64'(vecs[i].err));
            chk($sformatf("last_ra[v%0d]", i), 64'(last_ra[f]), 64'(vecs[i].lra));
            chk($sformatf("first_burst[v%0d]", i), 64'(first_burst[f]), 64'(vecs[i].fb));
        end

        // Exit fields hold after the strobe drops.
        step('0, '0, 16'h0, 16'h0, 10'h0, 6'h0, g);
        chk("hold_ra", 64'(ra_o), 64'(16'h30));
        chk("hold_type", 64'(type_o), 64'(1'b1));
        chk("hold_dq", 64'(dq_o), 64'(0));

        // Mid-stream reset with FIFOs 1, 2 and 6 occupied and a push/pop pending.
        do_reset(1'b1);

        // Wider instance: read FIFO 7, write FIFOs 8 and 12.
        step2(13'h1000, '0, 16'hC0C0, 16'h00C0, 1'b0, 16'h0, 16'h0, 1'b0);
        step2(13'h0080, '0, 16'h7777, 16'h0070, 1'b0, 16'h0, 16'h0, 1'b0);
        step2(13'h0100, '0, 16'h8888, 16'h0080, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("g2_count12", 64'(count2[12]), 64'(1));
        chk("g2_last_ra7", 64'(last_ra2[7]), 64'(16'h70));
        step2('0, 13'h1000, 16'h0, 16'h0, 1'b1, 16'h00C0, 16'hC0C0, 1'b0);
        step2('0, 13'h0080, 16'h0, 16'h0, 1'b1, 16'h0070, 16'h0000, 1'b1);
        step2('0, 13'h0100, 16'h0, 16'h0, 1'b1, 16'h0080, 16'h8888, 1'b0);
        step2('0, 13'h0100, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("g2_empty", 64'(empty2), 64'(13'h1FFF));
        chk("g2_udf", 64'(err_udf2), 64'(1));
        step2(13'h0400, '0, 16'hAAAA, 16'h00A0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("g2_count10", 64'(count2[10]), 64'(1));
        do_reset(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
